cic_dec4: RTL

Four-channel decimating CIC filter directly downstream of the dual-receiver mixer. It accepts the mixer's four 18-bit baseband streams (receiver 0 I/Q, receiver 1 I/Q) at one sample per `clk`, decimates by a fixed factor, and normalises the gain back to unity. It emits all four channels together with a single-cycle valid strobe.

---
 rtl/cic_dec4.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cic_dec4.sv
// cic_dec4: four-channel decimating CIC filter behind the dual-receiver mixer.
// Integrators run every cycle; one shared comb chain serves the channels in turn.
module cic_dec4 #(
  parameter int DECIMATION = 16,
  parameter int STAGES     = 3,
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  mixdata0_i,
  input  logic signed [IN_WIDTH-1:0]  mixdata0_q,
  input  logic signed [IN_WIDTH-1:0]  mixdata1_i,
  input  logic signed [IN_WIDTH-1:0]  mixdata1_q,
  output logic signed [OUT_WIDTH-1:0] cicdata0_i,
  output logic signed [OUT_WIDTH-1:0] cicdata0_q,
  output logic signed [OUT_WIDTH-1:0] cicdata1_i,
  output logic signed [OUT_WIDTH-1:0] cicdata1_q,
  output logic                        cic_valid
);

  localparam int LOG2R     = $clog2(DECIMATION);
  localparam int ACC_WIDTH = IN_WIDTH + STAGES * LOG2R;
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef enum logic [2:0] {
    IDLE, COMB0, COMB1, COMB2, COMB3, EMIT
  } state_t;

  localparam logic signed [ACC_WIDTH:0] HALF =
    (ACC_WIDTH+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAXW =
    {{(SHIFT+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINW =
    {{(SHIFT+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] MAXV =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MINV =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH-1:0]  in_w   [4];
  acc_t                        ext_w  [4];
  acc_t                        integ_q[4][STAGES];
  acc_t                        snap_q [4];
  acc_t                        dly_q  [4][STAGES];
  logic signed [OUT_WIDTH-1:0] hold_q [4];
  logic signed [OUT_WIDTH-1:0] out_q  [4];
  logic                        valid_q;
  logic [LOG2R-1:0]            cnt_q;
  logic [LOG2R-1:0]            cnt_d;
  state_t                      state_q;
  logic                        tick;
  logic [1:0]                  sel;
  acc_t                        x_w    [STAGES+1];
  logic signed [ACC_WIDTH:0]   rnd_w;
  logic signed [ACC_WIDTH:0]   sh_w;
  logic signed [OUT_WIDTH-1:0] sat_d;

  assign in_w[0] = mixdata0_i;
  assign in_w[1] = mixdata0_q;
  assign in_w[2] = mixdata1_i;
  assign in_w[3] = mixdata1_q;

  assign cicdata0_i = out_q[0];
  assign cicdata0_q = out_q[1];
  assign cicdata1_i = out_q[2];
  assign cicdata1_q = out_q[3];
  assign cic_valid  = valid_q;

  assign cnt_d = cnt_q + LOG2R'(1);
  assign tick  = (cnt_q == LOG2R'(DECIMATION - 1));

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      ext_w[c] = {{(ACC_WIDTH-IN_WIDTH){in_w[c][IN_WIDTH-1]}},
                  in_w[c]};
    end
  end

  // Modular accumulation: wrap-around cancels in the comb differences.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          integ_q[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        integ_q[c][0] <= integ_q[c][0] + ext_w[c];
        for (int k = 1; k < STAGES; k++) begin
          integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
        end
      end
    end
  end

  always_comb begin
    sel = 2'd0;
    case (state_q)
      COMB1:   sel = 2'd1;
      COMB2:   sel = 2'd2;
      COMB3:   sel = 2'd3;
      default: sel = 2'd0;
    endcase
    x_w[0] = snap_q[sel];
    for (int k = 0; k < STAGES; k++) begin
      x_w[k+1] = x_w[k] - dly_q[sel][k];
    end
    rnd_w = $signed({x_w[STAGES][ACC_WIDTH-1], x_w[STAGES]}) + HALF;
    sh_w  = rnd_w >>> SHIFT;
    if (sh_w > MAXW) begin
      sat_d = MAXV;
    end else if (sh_w < MINW) begin
      sat_d = MINV;
    end else begin
      sat_d = sh_w[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        snap_q[c] <= '0;
        hold_q[c] <= '0;
        out_q[c]  <= '0;
        for (int k = 0; k < STAGES; k++) begin
          dly_q[c][k] <= '0;
        end
      end
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      if (tick) begin
        for (int c = 0; c < 4; c++) begin
          snap_q[c] <= integ_q[c][STAGES-1];
        end
      end
      if (state_q inside {COMB0, COMB1, COMB2, COMB3}) begin
        for (int k = 0; k < STAGES; k++) begin
          dly_q[sel][k] <= x_w[k];
        end
        hold_q[sel] <= sat_d;
      end
      case (state_q)
        IDLE:    if (tick) state_q <= COMB0;
        COMB0:   state_q <= COMB1;
        COMB1:   state_q <= COMB2;
        COMB2:   state_q <= COMB3;
        COMB3:   state_q <= EMIT;
        EMIT: begin
          for (int c = 0; c < 4; c++) begin
            out_q[c] <= hold_q[c];
          end
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
